// File: rtl/sram_port_pkg.sv
// Shared constants, word/mask types and lane-parity helpers for the SRAM port controller.
package sram_port_pkg;

    localparam int unsigned LANES  = 32;
    localparam int unsigned LANE_W = 9;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WORD_W = LANES * LANE_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LANES-1:0]  mask_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        word_t data;
        mask_t perr;
    } rsp_entry_t;

    // Even parity: the returned bit makes the 9-bit lane carry an even number of ones.
    function automatic logic lane_parity(input logic [LANE_W-2:0] d);
        return ^d;
    endfunction

    function automatic word_t fill_parity(input word_t w);
        word_t r;
        r = w;
        for (int unsigned i = 0; i < LANES; i++) begin
            r[i*LANE_W + LANE_W-1] = lane_parity(w[i*LANE_W +: LANE_W-1]);
        end
        return r;
    endfunction

    function automatic mask_t check_parity(input word_t w);
        mask_t m;
        m = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            m[i] = w[i*LANE_W + LANE_W-1] ^ lane_parity(w[i*LANE_W +: LANE_W-1]);
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_port_rsp_fifo.sv
// In-order read-response FIFO holding captured data plus per-lane parity flags.
module sram_port_rsp_fifo
    import sram_port_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  word_t            push_data,
    input  mask_t            push_perr,
    input  logic             pop,
    output word_t            head_data,
    output mask_t            head_perr,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t       mem_q [DEPTH];
    rsp_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    // Wraps explicitly so non-power-of-two depths (3) stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{data: push_data, perr: push_perr};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        empty     = (count_q == '0);
        count     = count_q;
        head_data = empty ? '0 : mem_q[rd_ptr_q].data;
        head_perr = empty ? '0 : mem_q[rd_ptr_q].perr;
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for the 256x288 byte-masked one-port SRAM macro.
// Optional lane parity generation/checking enabled by SRAM_PORT_CTRL_PARITY_EN.
module sram_port_ctrl #(
    parameter int unsigned RSP_DEPTH = 2,
    parameter int unsigned LANES     = 32,
    parameter int unsigned LANE_W    = 9,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LANES*LANE_W-1:0] req_wdata,
    input  logic [LANES-1:0]        req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [LANES*LANE_W-1:0] rsp_rdata,
    output logic [LANES-1:0]        rsp_perr,
    input  logic                    volt_sel_in,
    output logic                    sram_valid,
    output logic                    sram_write,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [LANES*LANE_W-1:0] sram_wdata,
    output logic [LANES-1:0]        sram_wmask,
    input  logic [LANES*LANE_W-1:0] sram_rdata,
    output logic                    sram_volt_sel
);

    import sram_port_pkg::*;

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             rsp_pop;
    logic             accept;
    logic [3:0]       credits_used;
    word_t            wdata_fmt;
    mask_t            rd_perr;
    word_t            head_data;
    mask_t            head_perr;

    always_comb begin
`ifdef SRAM_PORT_CTRL_PARITY_EN
        wdata_fmt = fill_parity(req_wdata);
        rd_perr   = check_parity(sram_rdata);
`else
        wdata_fmt = req_wdata;
        rd_perr   = '0;
`endif
    end

    // Credits count both queued responses and the read whose data is on the bus this cycle;
    // a same-cycle pop returns its credit immediately so a full FIFO can still accept.
    always_comb begin
        rsp_pop      = rsp_valid & rsp_ready;
        credits_used = 4'(fifo_count) + 4'(inflight_q) - 4'(rsp_pop);
        req_ready    = ~reset & (credits_used < 4'(RSP_DEPTH));
        accept       = req_valid & req_ready;
        inflight_d   = accept & ~req_write;
    end

    always_comb begin
        sram_valid    = accept;
        sram_write    = accept & req_write;
        sram_addr     = accept ? req_addr  : '0;
        sram_wdata    = accept ? wdata_fmt : '0;
        sram_wmask    = accept ? req_wmask : '0;
        sram_volt_sel = volt_sel_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    sram_port_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (sram_rdata),
        .push_perr (rd_perr),
        .pop       (rsp_pop),
        .head_data (head_data),
        .head_perr (head_perr),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        rsp_valid = ~fifo_empty;
        rsp_rdata = head_data;
        rsp_perr  = head_perr;
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed self-checking bench for sram_port_ctrl with a behavioural SRAM macro model.
module tb_sram_port_ctrl;

    localparam int LANES     = 32;
    localparam int LANE_W    = 9;
    localparam int ADDR_W    = 8;
    localparam int W         = LANES * LANE_W;
    localparam int RSP_DEPTH = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [W-1:0]      req_wdata;
    logic [LANES-1:0]  req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_rdata;
    logic [LANES-1:0]  rsp_perr;
    logic              volt_sel_in;
    logic              sram_valid;
    logic              sram_write;
    logic [ADDR_W-1:0] sram_addr;
    logic [W-1:0]      sram_wdata;
    logic [LANES-1:0]  sram_wmask;
    logic [W-1:0]      sram_rdata;
    logic              sram_volt_sel;

    logic              bd_en;
    logic [ADDR_W-1:0] bd_addr;
    int                bd_bit;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sram_port_ctrl #(
        .RSP_DEPTH (RSP_DEPTH),
        .LANES     (LANES),
        .LANE_W    (LANE_W),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wmask     (req_wmask),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_perr      (rsp_perr),
        .volt_sel_in   (volt_sel_in),
        .sram_valid    (sram_valid),
        .sram_write    (sram_write),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_wmask    (sram_wmask),
        .sram_rdata    (sram_rdata),
        .sram_volt_sel (sram_volt_sel)
    );

    // Macro model: lane-masked write commit, read data registered for the next cycle.
    logic [W-1:0] mem [256];
    always @(posedge clock) begin
        if (sram_valid) begin
            if (sram_write) begin
                for (int i = 0; i < LANES; i++) begin
                    if (sram_wmask[i]) mem[sram_addr][i*LANE_W +: LANE_W] <= sram_wdata[i*LANE_W +: LANE_W];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end else if (bd_en) begin
            mem[bd_addr][bd_bit] <= ~mem[bd_addr][bd_bit];
        end
    end

    function automatic logic [W-1:0] fill(input logic [8:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] exp_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = w;
`ifdef SRAM_PORT_CTRL_PARITY_EN
        for (int i = 0; i < LANES; i++) begin
            logic [7:0] b;
            b = w[i*LANE_W +: 8];
            r[i*LANE_W + 8] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7];
        end
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [W-1:0] data, input logic [31:0] mask);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_wmask = mask;
        #1;
        checks++;
        if ({sram_valid, sram_write, sram_addr, sram_wmask} !== {1'b1, 1'b1, addr, mask}) begin
            errors++;
            $display("FAIL write_ctrl @%h: got v=%b w=%b a=%h m=%h expected v=1 w=1 a=%h m=%h",
                     addr, sram_valid, sram_write, sram_addr, sram_wmask, addr, mask);
        end
        checks++;
        if (sram_wdata !== exp_word(data)) begin
            errors++;
            $display("FAIL write_data @%h: got %h expected %h", addr, sram_wdata, exp_word(data));
        end
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic do_read_check(input logic [7:0] addr, input logic [W-1:0] exp_d, input logic [31:0] exp_p);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_accept @%h: got req_ready=%b expected 1", addr, req_ready);
        end
        tick();
        req_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_latency1 @%h: got rsp_valid=%b expected 0", addr, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_latency2 @%h: got rsp_valid=%b expected 1", addr, rsp_valid);
        end
        checks++;
        if (rsp_rdata !== exp_d) begin
            errors++;
            $display("FAIL read_data @%h: got %h expected %h", addr, rsp_rdata, exp_d);
        end
        checks++;
        if (rsp_perr !== exp_p) begin
            errors++;
            $display("FAIL read_perr @%h: got %h expected %h", addr, rsp_perr, exp_p);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_drain @%h: got rsp_valid=%b expected 0", addr, rsp_valid);
        end
    endtask

    task automatic check_rsp(input string name, input logic [W-1:0] exp_d);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d) begin
            errors++;
            $display("FAIL %s: got v=%b %h expected v=1 %h", name, rsp_valid, rsp_rdata, exp_d);
        end
    endtask

    task automatic check_ready(input string name, input logic exp_r);
        checks++;
        if (req_ready !== exp_r) begin
            errors++;
            $display("FAIL %s: got req_ready=%b expected %b", name, req_ready, exp_r);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h55;
        req_wdata = fill(9'h1FF); req_wmask = '1; rsp_ready = 1'b0; volt_sel_in = 1'b1;
        bd_en = 1'b0; bd_addr = '0; bd_bit = 0;
        tick();
        tick();
        req_valid = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_perr, sram_valid, sram_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b rv=%b perr=%h sv=%b sa=%h expected all 0",
                     req_ready, rsp_valid, rsp_perr, sram_valid, sram_addr);
        end
        checks++;
        if (sram_volt_sel !== 1'b1) begin
            errors++;
            $display("FAIL volt_sel_hi: got %b expected 1", sram_volt_sel);
        end
        req_valid = 1'b0;
        reset = 1'b0;
        volt_sel_in = 1'b0;
        #1;
        check_ready("ready_after_reset", 1'b1);
        checks++;
        if ({rsp_valid, sram_valid, sram_write, sram_addr, sram_wdata, sram_wmask, sram_volt_sel} !== '0) begin
            errors++;
            $display("FAIL idle_pins: got v=%b sv=%b sa=%h sm=%h vs=%b expected all 0",
                     rsp_valid, sram_valid, sram_addr, sram_wmask, sram_volt_sel);
        end
        tick();
    endtask

    task automatic test_write_read();
        do_write(8'h10, fill(9'h0AB), '1);
        do_read_check(8'h10, exp_word(fill(9'h0AB)), '0);
    endtask

    task automatic test_wmask();
        logic [W-1:0] e;
        do_write(8'h20, fill(9'h111), '1);
        do_write(8'h20, fill(9'h0FF), 32'h0000_000F);
        e = exp_word(fill(9'h111));
        for (int i = 0; i < 4; i++) e[i*LANE_W +: LANE_W] = 9'h0FF;
        do_read_check(8'h20, e, '0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) do_write(8'h40 + 8'(i), fill(9'h0C0 + 9'(i)), '1);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40;
        #1; check_ready("bp_acc0", 1'b1);
        tick();
        req_addr = 8'h41;
        #1; check_ready("bp_acc1", 1'b1);
        tick();
        req_addr = 8'h42;
        #1; check_ready("bp_stall0", 1'b0);
        checks++;
        if (sram_valid !== 1'b0 || sram_addr !== '0) begin
            errors++;
            $display("FAIL bp_pins: got sv=%b sa=%h expected 0 00", sram_valid, sram_addr);
        end
        tick();
        check_ready("bp_stall1", 1'b0);
        check_rsp("bp_rsp0", exp_word(fill(9'h0C0)));
        rsp_ready = 1'b1;
        #1; check_ready("bp_resume", 1'b1);
        tick();
        req_addr = 8'h43;
        #1;
        check_rsp("bp_rsp1", exp_word(fill(9'h0C1)));
        check_ready("bp_acc3", 1'b1);
        tick();
        req_valid = 1'b0;
        #1; check_rsp("bp_rsp2", exp_word(fill(9'h0C2)));
        tick();
        check_rsp("bp_rsp3", exp_word(fill(9'h0C3)));
        tick();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_full_pop_read();
        for (int i = 0; i < 3; i++) do_write(8'h50 + 8'(i), fill(9'h0D0 + 9'(i)), '1);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h50;
        tick();
        req_addr = 8'h51;
        tick();
        req_valid = 1'b0;
        tick();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 8'h52;
        #1;
        check_ready("full_pop_accept", 1'b1);
        check_rsp("full_rsp0", exp_word(fill(9'h0D0)));
        tick();
        rsp_ready = 1'b0;
        req_addr = 8'h53;
        #1; check_ready("full_count_kept", 1'b0);
        tick();
        check_ready("full_again", 1'b0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1; check_rsp("full_rsp1", exp_word(fill(9'h0D1)));
        tick();
        check_rsp("full_rsp2", exp_word(fill(9'h0D2)));
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = (i < 4);
            req_write = 1'b0;
            req_addr  = 8'h40 + 8'(i);
            #1;
            if (i < 4) check_ready("b2b_ready", 1'b1);
            if (i >= 2) check_rsp("b2b_rsp", exp_word(fill(9'h0C0 + 9'(i - 2))));
            tick();
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_read_then_write();
        do_write(8'h60, fill(9'h0E1), '1);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h60;
        tick();
        req_write = 1'b1; req_wdata = fill(9'h02A); req_wmask = '1;
        #1; check_ready("rtw_write_accept", 1'b1);
        tick();
        req_valid = 1'b0; req_write = 1'b0;
        #1; check_rsp("rtw_old_data", exp_word(fill(9'h0E1)));
        rsp_ready = 1'b1;
        tick();
        do_read_check(8'h60, exp_word(fill(9'h02A)), '0);
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_ready("rst_mid_ready", 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_rsp: got rsp_valid=%b expected 0", rsp_valid);
            end
            tick();
        end
        do_read_check(8'h10, exp_word(fill(9'h0AB)), '0);
    endtask

    task automatic test_parity();
        logic [W-1:0] e;
        logic [31:0]  p;
        do_write(8'h30, fill(9'h0FF), '1);
        bd_en = 1'b1; bd_addr = 8'h30; bd_bit = 5 * LANE_W + 3;
        tick();
        bd_en = 1'b0;
        e = exp_word(fill(9'h0FF));
        e[5*LANE_W +: LANE_W] = 9'h0F7;
`ifdef SRAM_PORT_CTRL_PARITY_EN
        p = 32'h0000_0020;
`else
        p = 32'h0000_0000;
`endif
        do_read_check(8'h30, e, p);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wmask();
        test_backpressure();
        test_full_pop_read();
        test_back_to_back();
        test_read_then_write();
        test_reset_mid();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Initiator-side controller for the 256x288 one-port byte-masked SRAM macro: 32 lanes of 9 bits, 8-bit address, read data valid one cycle after the read strobe.
- Accepts read/write requests on a valid/ready request channel and drives the macro's valid/write/addr/wdata/wmask/volt_sel pins.
- Captures read data into a response FIFO so read responses can be backpressured without losing data.
- Sits between a vector/TCM arbiter and the memory macro.

Parameters:
RSP_DEPTH, 2, response FIFO entries; legal values 1..4.
LANES, 32, byte lanes per word.
LANE_W, 9, bits per lane (8 data + 1 spare/parity).
ADDR_W, 8, word address width.

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  LANES*LANE_W  write data
req_wmask  in  LANES  per-lane write enable
rsp_valid  out  1  read response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  LANES*LANE_W  read data
rsp_perr  out  LANES  per-lane parity error (see optional feature)
volt_sel_in  in  1  voltage select from power control
sram_valid  out  1  macro access strobe
sram_write  out  1  macro write
sram_addr  out  ADDR_W  macro address
sram_wdata  out  LANES*LANE_W  macro write data
sram_wmask  out  LANES  macro lane mask
sram_rdata  in  LANES*LANE_W  macro read data
sram_volt_sel  out  1  wire from volt_sel_in

Behaviour:
- One clock (clock); reset is synchronous and active-high (reset).
- Reset values: req_ready=0 during reset, 1 on the first cycle after reset; rsp_valid=0; rsp_perr=0; FIFO empty; inflight=0.
- sram_* pins are combinational from the request channel:
  - sram_valid = req_valid & req_ready.
  - sram_write, sram_addr, sram_wdata, sram_wmask pass through from req_*.
  - When sram_valid=0, all sram_* pins except sram_volt_sel are 0.
- Write: accepted in cycle N; the macro commits at the end of cycle N; no response is produced. A write with req_wmask=0 is still issued and is harmless.
- Read: accepted in cycle N sets the inflight flag at the end of N.
  - In cycle N+1, sram_rdata is valid and is pushed into the FIFO at the end of N+1 (inflight clears).
  - rsp_valid is first seen in cycle N+2, so latency is 2 cycles.
- Flow control:
  - outstanding = fifo_count + inflight.
  - req_ready = (outstanding - pop) < RSP_DEPTH, where pop = rsp_valid & rsp_ready in the same cycle.
  - req_ready is independent of req_write: writes stall when credits run out.
- The FIFO never overflows (guaranteed by credits). It outputs in order; rsp_rdata and rsp_perr come from the head entry and are 0 when empty.
- Simultaneous push and pop in one cycle: count unchanged.
- Pop at full while a read is accepted in the same cycle is legal.
- Read-then-write to the same address in consecutive cycles: the response carries the pre-write data, because capture happens at the same edge as the write commit.
- Back-to-back reads sustain 1 per cycle when RSP_DEPTH >= 2 and rsp_ready is held at 1.
- Reset mid-operation: inflight read and all FIFO contents are discarded, no rsp_valid afterwards. The macro contents are untouched.

Optional Feature:
SRAM_PORT_CTRL_PARITY_EN
- Defined, write path: bit 8 of each lane on sram_wdata is replaced by the even parity of that lane's bits 7:0.
- Defined, read path: each captured lane is checked; rsp_perr[i]=1 when lane i's bit 8 differs from the parity of bits 7:0. rsp_perr is stored in the FIFO alongside the data.
- Undefined: sram_wdata equals req_wdata unmodified, and rsp_perr is constant 0.

Decomposition:
- Package sram_port_pkg holds:
  - LANES, LANE_W, ADDR_W constants.
  - word_t and mask_t typedefs.
  - A lane-parity function.
- One sub-module, sram_port_rsp_fifo: depth RSP_DEPTH, payload word_t + mask_t, with push/pop/count interface.

Test Plan:
- Write addr 0x10 data all lanes 0x0AB, mask all 1s; read 0x10 -> rsp_valid 2 cycles after accept, rsp_rdata lanes = 0x0AB.
- Write 0x20 all 0x111; then write lanes 0..3 = 0x0FF with wmask=0x0000000F; read 0x20 -> lanes 0..3 = 0x0FF, lanes 4..31 = 0x111.
- rsp_ready=0, 4 reads issued, RSP_DEPTH=2 -> exactly 2 accepted, req_ready=0 from the cycle after the 2nd accept; raise rsp_ready -> responses in issue order, remaining reads then accepted.
- FIFO full, rsp_ready=1 and a new read in the same cycle -> read accepted, no data lost, count stays at 2.
- Read accepted, reset asserted the next cycle -> rsp_valid stays 0 after reset, req_ready=1 one cycle after reset deasserts.
- With SRAM_PORT_CTRL_PARITY_EN: write 0x30 lanes 0x0FF, then backdoor-flip bit 3 of lane 5 in the macro; read 0x30 -> rsp_perr = 0x00000020. Without the macro, rsp_perr = 0.
